load_port_arbiter: RTL



---
 rtl/load_arb_pkg.sv | 32 +++
 rtl/load_port_arbiter_if.sv | 29 ++
 rtl/load_arb_id_fifo.sv | 60 ++++++
 rtl/load_port_arbiter.sv | 92 +++++++++
 4 files changed

// File: rtl/load_arb_pkg.sv
// Shared helpers for the load port arbiter: ID width, round-robin search, reset values.
package load_arb_pkg;

    localparam int MAX_PORTS   = 32;
    localparam int RESET_PTR   = 0;
    localparam int RESET_COUNT = 0;

    function automatic int idWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Returns the first set index of valid[0 +: n] scanning from start with wrap; 0 if none set.
    function automatic int rrSearch(input logic [MAX_PORTS-1:0] valid, input int start, input int n);
        int   idx;
        int   result;
        logic found;
        found  = 1'b0;
        result = 0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n && !found) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (valid[idx]) begin
                    found  = 1'b1;
                    result = idx;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/load_port_arbiter_if.sv
// Bundle of the per-port load channels and the shared memory load channel.
interface load_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_TYPE = 32,
    parameter int ADDR_TYPE = 32
);
    logic [NUM_PORTS*ADDR_TYPE-1:0] addrIn;
    logic [NUM_PORTS-1:0]           addrIn_valid;
    logic [NUM_PORTS-1:0]           addrIn_ready;
    logic [ADDR_TYPE-1:0]           addrOut;
    logic                           addrOut_valid;
    logic                           addrOut_ready;
    logic [DATA_TYPE-1:0]           dataFromMem;
    logic                           dataFromMem_valid;
    logic                           dataFromMem_ready;
    logic [NUM_PORTS*DATA_TYPE-1:0] dataOut;
    logic [NUM_PORTS-1:0]           dataOut_valid;
    logic [NUM_PORTS-1:0]           dataOut_ready;

    // master is the arbiter itself; slave is the surrounding load units and memory interface.
    modport master (
        input  addrIn, addrIn_valid, addrOut_ready, dataFromMem, dataFromMem_valid, dataOut_ready,
        output addrIn_ready, addrOut, addrOut_valid, dataFromMem_ready, dataOut, dataOut_valid
    );
    modport slave (
        output addrIn, addrIn_valid, addrOut_ready, dataFromMem, dataFromMem_valid, dataOut_ready,
        input  addrIn_ready, addrOut, addrOut_valid, dataFromMem_ready, dataOut, dataOut_valid
    );
endinterface

// File: rtl/load_arb_id_fifo.sv
// FIFO of issuing port IDs; the head is read combinationally so returns route with zero latency.
module load_arb_id_fifo
    import load_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushId,
    input  logic             pop,
    output logic [WIDTH-1:0] headId,
    output logic [CNTW-1:0]  count,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [CNTW-1:0]  countReg;
    logic             full;
    logic             pushOk;
    logic             popOk;

    function automatic logic [AW-1:0] advance(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full   = (countReg == CNTW'(DEPTH));
    assign empty  = (countReg == '0);
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;
    assign count  = countReg;
    assign headId = mem[rdPtrReg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= CNTW'(RESET_COUNT);
        end else begin
            if (pushOk) wrPtrReg <= advance(wrPtrReg);
            if (popOk)  rdPtrReg <= advance(rdPtrReg);
            case ({pushOk, popOk})
                2'b10:   countReg <= countReg + CNTW'(1);
                2'b01:   countReg <= countReg - CNTW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every use of the head.
    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtrReg] <= pushId;
    end

endmodule

// File: rtl/load_port_arbiter.sv
// Shares one memory load channel among NUM_PORTS load ports; returns are routed by issue order.
// Define LOAD_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module load_port_arbiter
    import load_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DATA_TYPE       = 32,
    parameter int ADDR_TYPE       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    load_port_arbiter_if.master bus
);
    localparam int IDW  = idWidth(NUM_PORTS);
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    logic [MAX_PORTS-1:0] validPad;
    logic                 anyValid;
    logic [IDW-1:0]       grantId;
    logic [IDW-1:0]       searchStart;
    logic [IDW-1:0]       headId;
    logic [CNTW-1:0]      fifoCount;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 addrOutValid;
    logic                 dataFromMemReady;
    logic                 issueFire;
    logic                 returnFire;

`ifdef LOAD_ARB_FIXED_PRIO_EN
    assign searchStart = '0;
`else
    logic [IDW-1:0] ptrReg;
    logic [IDW-1:0] ptrNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptrReg <= IDW'(RESET_PTR);
        else     ptrReg <= ptrNext;
    end

    // Explicit wrap keeps non-power-of-two port counts inside range.
    always_comb begin
        ptrNext = ptrReg;
        if (issueFire) ptrNext = (grantId == IDW'(NUM_PORTS - 1)) ? '0 : grantId + IDW'(1);
    end

    assign searchStart = ptrReg;
`endif

    always_comb begin
        validPad                 = '0;
        validPad[NUM_PORTS-1:0]  = bus.addrIn_valid;
        anyValid                 = |bus.addrIn_valid;
        grantId                  = IDW'(rrSearch(validPad, int'(searchStart), NUM_PORTS));
    end

    assign fifoFull         = (fifoCount == CNTW'(MAX_OUTSTANDING));
    assign addrOutValid     = !rst && anyValid && !fifoFull;
    assign dataFromMemReady = !rst && !fifoEmpty && bus.dataOut_ready[headId];
    assign issueFire        = addrOutValid && bus.addrOut_ready;
    assign returnFire       = bus.dataFromMem_valid && dataFromMemReady;

    assign bus.addrOut_valid     = addrOutValid;
    assign bus.dataFromMem_ready = dataFromMemReady;
    assign bus.addrOut           = (rst || !anyValid) ? '0 : bus.addrIn[grantId*ADDR_TYPE +: ADDR_TYPE];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : gPort
            assign bus.addrIn_ready[gi]                     = addrOutValid && bus.addrOut_ready && (grantId == IDW'(gi));
            assign bus.dataOut[gi*DATA_TYPE +: DATA_TYPE]   = bus.dataFromMem;
            assign bus.dataOut_valid[gi]                    = !rst && bus.dataFromMem_valid && !fifoEmpty && (headId == IDW'(gi));
        end
    endgenerate

    load_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW),
        .CNTW  (CNTW)
    ) idFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (issueFire),
        .pushId (grantId),
        .pop    (returnFire),
        .headId (headId),
        .count  (fifoCount),
        .empty  (fifoEmpty)
    );

endmodule
